// File: rtl/and_event_monitor.sv
// Synchronizes one gate result into clk, glitch-filters it, and reports each
// filtered high pulse width on a valid/ready handshake with a saturating event count.
module and_event_monitor #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c_in,
  input  logic             clear,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [CNT_W-1:0] evt_width,
  output logic [CNT_W-1:0] evt_count,
  output logic             overflow,
  output logic             level
);

  localparam int FILT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic {S_LOW, S_HIGH} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic [FILT_W-1:0]      filt_q, filt_d;
  logic                   level_q;
  logic                   toggle;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       width_q, width_d;
  logic                   complete;
  logic                   evt_valid_q;
  logic [CNT_W-1:0]       evt_width_q;
  logic [CNT_W-1:0]       evt_count_q;
  logic                   overflow_q;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Counter runs 0..FILTER_LEN-1; the mismatch that would make it reach
  // FILTER_LEN flips the level instead.
  always_comb begin
    filt_d = '0;
    toggle = 1'b0;
    if (sync_out != level_q) begin
      if (filt_q == FILT_W'(FILTER_LEN - 1)) toggle = 1'b1;
      else                                   filt_d = filt_q + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    complete = 1'b0;
    case (state_q)
      S_LOW: begin
        if (toggle) begin
          state_d = S_HIGH;
          width_d = CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (toggle) begin
          state_d  = S_LOW;
          complete = 1'b1;
          width_d  = '0;
        end else if (width_q != '1) begin
          width_d = width_q + 1'b1;
        end
      end
      default: state_d = S_LOW;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      filt_q  <= '0;
      level_q <= 1'b0;
      state_q <= S_LOW;
      width_q <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], c_in};
      filt_q  <= filt_d;
      level_q <= level_q ^ toggle;
      state_q <= state_d;
      width_q <= width_d;
    end
  end

  // A pending record is only replaced when it is consumed in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      evt_valid_q <= 1'b0;
      evt_width_q <= '0;
      evt_count_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (complete && (!evt_valid_q || evt_ready)) begin
        evt_valid_q <= 1'b1;
        evt_width_q <= width_q;
      end else if (evt_valid_q && evt_ready) begin
        evt_valid_q <= 1'b0;
      end

      if (clear)                                evt_count_q <= '0;
      else if (complete && evt_count_q != '1)   evt_count_q <= evt_count_q + 1'b1;

      if (clear)                                     overflow_q <= 1'b0;
      else if (complete && evt_valid_q && !evt_ready) overflow_q <= 1'b1;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_width = evt_width_q;
  assign evt_count = evt_count_q;
  assign overflow  = overflow_q;
  assign level     = level_q;

endmodule

// File: tb/tb_and_event_monitor.sv
// Directed bench: default-parameter monitor plus a CNT_W=4 instance for saturation.
module tb_and_event_monitor;

  logic        clk = 1'b0;
  logic        reset, c_in, c_in2, clear, evt_ready;
  logic        evt_valid, overflow, level;
  logic [15:0] evt_width, evt_count;
  logic        evt_valid2, overflow2, level2;
  logic [3:0]  evt_width2, evt_count2;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  and_event_monitor #(.CNT_W(16), .SYNC_STAGES(2), .FILTER_LEN(3)) dut (
    .clk(clk), .reset(reset), .c_in(c_in), .clear(clear), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_width(evt_width), .evt_count(evt_count),
    .overflow(overflow), .level(level)
  );

  and_event_monitor #(.CNT_W(4), .SYNC_STAGES(2), .FILTER_LEN(3)) dut_sat (
    .clk(clk), .reset(reset), .c_in(c_in2), .clear(clear), .evt_ready(evt_ready),
    .evt_valid(evt_valid2), .evt_width(evt_width2), .evt_count(evt_count2),
    .overflow(overflow2), .level(level2)
  );

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; c_in = 1'b0; c_in2 = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // High for n sampling edges, then low long enough for the fall to complete.
  task automatic pulse(input int n, input bit sat);
    @(negedge clk);
    if (sat) c_in2 = 1'b1; else c_in = 1'b1;
    repeat (n) @(negedge clk);
    if (sat) c_in2 = 1'b0; else c_in = 1'b0;
    repeat (7) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++;
    if ({level, evt_valid, overflow} !== 3'b000 || evt_width !== 16'd0 || evt_count !== 16'd0)
      $display("FAIL reset_state: got lvl=%0b vld=%0b ovf=%0b w=%0d cnt=%0d expected all 0",
               level, evt_valid, overflow, evt_width, evt_count);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    evt_ready = 1'b1;
    @(negedge clk);
    c_in = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (level !== 1'b0) $display("FAIL basic_level_early: got %0b expected 0", level);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (level !== 1'b1) $display("FAIL basic_level_rise: got %0b expected 1", level);
    else pass_cnt++;
    repeat (5) @(negedge clk);
    c_in = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (evt_valid !== 1'b0 || level !== 1'b1)
      $display("FAIL basic_before_fall: got vld=%0b lvl=%0b expected 0/1", evt_valid, level);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (evt_valid !== 1'b1 || evt_width !== 16'd10 || level !== 1'b0)
      $display("FAIL basic_event: got vld=%0b w=%0d lvl=%0b expected 1/10/0", evt_valid, evt_width, level);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (evt_valid !== 1'b0 || evt_count !== 16'd1 || overflow !== 1'b0)
      $display("FAIL basic_after: got vld=%0b cnt=%0d ovf=%0b expected 0/1/0", evt_valid, evt_count, overflow);
    else pass_cnt++;
  endtask

  task automatic test_glitch();
    bit seen;
    do_reset();
    seen = 1'b0;
    @(negedge clk);
    c_in = 1'b1;
    repeat (2) @(negedge clk);
    c_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (level || evt_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) $display("FAIL glitch_level: got activity=%0b expected 0", seen);
    else pass_cnt++;
    total++;
    if (evt_count !== 16'd0) $display("FAIL glitch_count: got %0d expected 0", evt_count);
    else pass_cnt++;
  endtask

  task automatic test_no_accept();
    do_reset();
    evt_ready = 1'b0;
    pulse(8, 1'b0);
    total++;
    if (evt_valid !== 1'b1 || evt_width !== 16'd8 || overflow !== 1'b0)
      $display("FAIL noacc_first: got vld=%0b w=%0d ovf=%0b expected 1/8/0", evt_valid, evt_width, overflow);
    else pass_cnt++;
    pulse(12, 1'b0);
    total++;
    if (evt_valid !== 1'b1 || evt_width !== 16'd8)
      $display("FAIL noacc_hold: got vld=%0b w=%0d expected 1/8", evt_valid, evt_width);
    else pass_cnt++;
    total++;
    if (evt_count !== 16'd2 || overflow !== 1'b1)
      $display("FAIL noacc_ovf: got cnt=%0d ovf=%0b expected 2/1", evt_count, overflow);
    else pass_cnt++;
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    total++;
    if (evt_count !== 16'd0 || overflow !== 1'b0 || evt_valid !== 1'b1 || evt_width !== 16'd8)
      $display("FAIL noacc_clear: got cnt=%0d ovf=%0b vld=%0b w=%0d expected 0/0/1/8",
               evt_count, overflow, evt_valid, evt_width);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    evt_ready = 1'b0;
    pulse(8, 1'b0);
    @(negedge clk);
    c_in = 1'b1;
    repeat (6) @(negedge clk);
    c_in = 1'b0;
    repeat (4) @(negedge clk);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    total++;
    if (evt_valid !== 1'b1 || evt_width !== 16'd6 || overflow !== 1'b0)
      $display("FAIL b2b_load: got vld=%0b w=%0d ovf=%0b expected 1/6/0", evt_valid, evt_width, overflow);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (evt_valid !== 1'b1 || evt_width !== 16'd6 || evt_count !== 16'd2)
      $display("FAIL b2b_hold: got vld=%0b w=%0d cnt=%0d expected 1/6/2", evt_valid, evt_width, evt_count);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    do_reset();
    evt_ready = 1'b1;
    pulse(20, 1'b1);
    total++;
    if (evt_width2 !== 4'd15 || evt_count2 !== 4'd1)
      $display("FAIL sat_width: got w=%0d cnt=%0d expected 15/1", evt_width2, evt_count2);
    else pass_cnt++;
    for (int i = 0; i < 16; i++) pulse(4, 1'b1);
    total++;
    if (evt_count2 !== 4'd15 || evt_width2 !== 4'd4 || overflow2 !== 1'b0)
      $display("FAIL sat_count: got cnt=%0d w=%0d ovf=%0b expected 15/4/0", evt_count2, evt_width2, overflow2);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_pulse();
    bit seen;
    do_reset();
    evt_ready = 1'b1;
    @(negedge clk);
    c_in = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({level, evt_valid, overflow} !== 3'b000 || evt_width !== 16'd0 || evt_count !== 16'd0)
      $display("FAIL midrst_state: got lvl=%0b vld=%0b ovf=%0b w=%0d cnt=%0d expected all 0",
               level, evt_valid, overflow, evt_width, evt_count);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    c_in = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (evt_valid || level) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0 || evt_count !== 16'd0)
      $display("FAIL midrst_noevt: got activity=%0b cnt=%0d expected 0/0", seen, evt_count);
    else pass_cnt++;
    evt_ready = 1'b0;
    pulse(9, 1'b0);
    total++;
    if (evt_valid !== 1'b1 || evt_width !== 16'd9 || evt_count !== 16'd1)
      $display("FAIL midrst_next: got vld=%0b w=%0d cnt=%0d expected 1/9/1", evt_valid, evt_width, evt_count);
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; c_in = 1'b0; c_in2 = 1'b0; clear = 1'b0; evt_ready = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_no_accept();
    test_back_to_back();
    test_saturation();
    test_reset_mid_pulse();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
